// File: rtl/fpu_op_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_op_sequencer
//   Single-outstanding-operation controller in front of the 8-bit FPU
//   datapath. Accepts one {op, A, B} request, presents the registered
//   operands to the exception checker, and then either returns a substituted
//   result (exception path) or runs the arithmetic unit with a timeout
//   (datapath path). Results leave over a valid/ready handshake. Sticky
//   exception flags are kept for software.
//
// Ports
//   CLK, RST_N                     clock (rising edge), async active-low reset
//   IN_VALID/IN_READY              request handshake
//   IN_OP, IN_A, IN_B              request operation and operands
//   EXC_OP, EXC_A, EXC_B           registered request to the exception checker
//   EXC_IS_EXCEPTION, EXC_CODE     checker response (combinational from EXC_*)
//   DP_START                       one-cycle start pulse to the arithmetic unit
//   DP_DONE, DP_RESULT             arithmetic unit completion and result
//   OUT_VALID/OUT_READY            result handshake
//   OUT_RESULT, OUT_EXCE           result and its exception code
//   OUT_TIMEOUT                    result came from a timeout abort
//   CLR_STICKY                     clear sticky flags
//   STICKY                         {timeout, div_zero, invalid}
// ---------------------------------------------------------------------------

`ifndef _NO_EXCE
`define _NO_EXCE       3'd0
`define _qNAN_EXCE     3'd1
`define _sNAN_EXCE     3'd2
`define _INF_EXCE      3'd3
`define _ZERO_DIV_EXCE 3'd4
`endif

`ifndef _ADDITION
`define _ADDITION       2'd0
`define _SUBTRACTION    2'd1
`define _MULTIPLICATION 2'd2
`define _DIVISION       2'd3
`endif

module fpu_op_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [7:0]  CANON_NAN      = 8'hFF,
    parameter logic [6:0]  INF_MAG        = 7'h78
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [1:0] IN_OP,
    input  logic [7:0] IN_A,
    input  logic [7:0] IN_B,
    output logic [1:0] EXC_OP,
    output logic [7:0] EXC_A,
    output logic [7:0] EXC_B,
    input  logic       EXC_IS_EXCEPTION,
    input  logic [2:0] EXC_CODE,
    output logic       DP_START,
    input  logic       DP_DONE,
    input  logic [7:0] DP_RESULT,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [7:0] OUT_RESULT,
    output logic [2:0] OUT_EXCE,
    output logic       OUT_TIMEOUT,
    input  logic       CLR_STICKY,
    output logic [2:0] STICKY
);

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned   CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    sticky_set;
    logic          code_invalid;
    logic          code_div_zero;
    logic          exec_timeout;

    assign IN_READY = (state == IDLE);

    // The checker answers combinationally from EXC_*, which are only valid
    // from the CHECK cycle on, so the start pulse cannot be registered
    // without losing a cycle: it is decoded from the CHECK state instead.
    assign DP_START = (state == CHECK) && !EXC_IS_EXCEPTION;

    assign code_invalid  = (EXC_CODE == `_qNAN_EXCE) ||
                           (EXC_CODE == `_sNAN_EXCE) ||
                           (EXC_CODE == `_INF_EXCE);
    assign code_div_zero = (EXC_CODE == `_ZERO_DIV_EXCE);

    // DP_DONE has priority over an expiring counter in the same cycle.
    assign exec_timeout = (state == EXEC) && !DP_DONE && (cnt == CNT_LAST);

    // Flags to raise on the edge that enters DONE.
    always_comb begin
        sticky_set = 3'b000;
        if (state == CHECK && EXC_IS_EXCEPTION) begin
            sticky_set[0] = code_invalid;
            sticky_set[1] = code_div_zero;
        end
        if (exec_timeout)
            sticky_set[2] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            cnt         <= '0;
            EXC_OP      <= 2'd0;
            EXC_A       <= 8'd0;
            EXC_B       <= 8'd0;
            OUT_VALID   <= 1'b0;
            OUT_RESULT  <= 8'd0;
            OUT_EXCE    <= `_NO_EXCE;
            OUT_TIMEOUT <= 1'b0;
            STICKY      <= 3'b000;
        end else begin
            // A set in the same cycle as a clear wins for that bit.
            STICKY <= (CLR_STICKY ? 3'b000 : STICKY) | sticky_set;

            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        EXC_OP <= IN_OP;
                        EXC_A  <= IN_A;
                        EXC_B  <= IN_B;
                        state  <= CHECK;
                    end
                end

                CHECK: begin
                    if (EXC_IS_EXCEPTION) begin
                        // Bypass the arithmetic unit with a substituted result.
                        OUT_EXCE    <= EXC_CODE;
                        OUT_RESULT  <= code_div_zero ? {EXC_A[7] ^ EXC_B[7], INF_MAG}
                                                     : CANON_NAN;
                        OUT_TIMEOUT <= 1'b0;
                        OUT_VALID   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt   <= '0;
                        state <= EXEC;
                    end
                end

                EXEC: begin
                    if (DP_DONE) begin
                        OUT_RESULT  <= DP_RESULT;
                        OUT_EXCE    <= `_NO_EXCE;
                        OUT_TIMEOUT <= 1'b0;
                        OUT_VALID   <= 1'b1;
                        state       <= DONE;
                    end else if (exec_timeout) begin
                        OUT_RESULT  <= CANON_NAN;
                        OUT_EXCE    <= `_NO_EXCE;
                        OUT_TIMEOUT <= 1'b1;
                        OUT_VALID   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                DONE: begin
                    // Result and code are held until the consumer takes them.
                    if (OUT_READY) begin
                        OUT_VALID   <= 1'b0;
                        OUT_TIMEOUT <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fpu_op_sequencer
//   Drives requests, a small exception checker and an arithmetic-unit stub
//   whose completion delay is chosen per transaction. A transaction-level
//   model predicts, for every cycle, readiness, start pulse, result timing,
//   result contents and sticky flags from the cycle count since acceptance.
// ---------------------------------------------------------------------------

`ifndef _NO_EXCE
`define _NO_EXCE       3'd0
`define _qNAN_EXCE     3'd1
`define _sNAN_EXCE     3'd2
`define _INF_EXCE      3'd3
`define _ZERO_DIV_EXCE 3'd4
`endif

`ifndef _ADDITION
`define _ADDITION       2'd0
`define _SUBTRACTION    2'd1
`define _MULTIPLICATION 2'd2
`define _DIVISION       2'd3
`endif

module tb_fpu_op_sequencer;

    localparam int TO = 16;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [1:0] IN_OP = 2'd0;
    logic [7:0] IN_A = 8'd0;
    logic [7:0] IN_B = 8'd0;
    logic [1:0] EXC_OP;
    logic [7:0] EXC_A;
    logic [7:0] EXC_B;
    logic       EXC_IS_EXCEPTION;
    logic [2:0] EXC_CODE;
    logic       DP_START;
    logic       DP_DONE = 1'b0;
    logic [7:0] DP_RESULT = 8'd0;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic [7:0] OUT_RESULT;
    logic [2:0] OUT_EXCE;
    logic       OUT_TIMEOUT;
    logic       CLR_STICKY = 1'b0;
    logic [2:0] STICKY;

    always #5 CLK = ~CLK;

    fpu_op_sequencer #(.TIMEOUT_CYCLES(TO), .CANON_NAN(8'hFF), .INF_MAG(7'h78)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OP(IN_OP), .IN_A(IN_A), .IN_B(IN_B),
        .EXC_OP(EXC_OP), .EXC_A(EXC_A), .EXC_B(EXC_B),
        .EXC_IS_EXCEPTION(EXC_IS_EXCEPTION), .EXC_CODE(EXC_CODE),
        .DP_START(DP_START), .DP_DONE(DP_DONE), .DP_RESULT(DP_RESULT),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_RESULT(OUT_RESULT),
        .OUT_EXCE(OUT_EXCE), .OUT_TIMEOUT(OUT_TIMEOUT),
        .CLR_STICKY(CLR_STICKY), .STICKY(STICKY)
    );

    // Minimal exception checker for a 1-4-3 format: exponent all ones with
    // nonzero mantissa is NaN (mantissa MSB clear = signalling), zero
    // mantissa is infinity; division by a zero magnitude is div-by-zero.
    function automatic logic [2:0] chk_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic an, bn, ai, bi;
        an = (a[6:3] == 4'hF) && (a[2:0] != 3'd0);
        bn = (b[6:3] == 4'hF) && (b[2:0] != 3'd0);
        ai = (a[6:3] == 4'hF) && (a[2:0] == 3'd0);
        bi = (b[6:3] == 4'hF) && (b[2:0] == 3'd0);
        if (an || bn) return ((an && !a[2]) || (bn && !b[2])) ? `_sNAN_EXCE : `_qNAN_EXCE;
        if (ai || bi) return `_INF_EXCE;
        if (op == `_DIVISION && b[6:0] == 7'd0) return `_ZERO_DIV_EXCE;
        return `_NO_EXCE;
    endfunction

    assign EXC_CODE         = chk_fn(EXC_OP, EXC_A, EXC_B);
    assign EXC_IS_EXCEPTION = (EXC_CODE != `_NO_EXCE);

    int checks = 0;
    int failures = 0;
    int dp_starts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus knobs, applied every cycle.
    bit         k_iv, k_ordy, k_clr, k_sp;
    logic [1:0] k_op;
    logic [7:0] k_a, k_b, k_dpres;
    int         k_d;

    // Transaction model: m_cyc counts cycles since the accept edge
    // (1 = first cycle after it); m_lat is the first cycle with a result.
    bit         m_busy, m_exc, m_to;
    int         m_cyc, m_lat, m_d;
    logic [1:0] m_op;
    logic [7:0] m_a, m_b, m_res, m_dpres;
    logic [2:0] m_code, m_set, m_sticky;

    function automatic bit m_in_exec();
        return m_busy && !m_exc && m_cyc >= 2 && m_cyc < m_lat;
    endfunction

    task automatic apply_inputs();
        bit done_now;
        done_now   = m_in_exec() && (m_d <= TO) && (m_cyc == 1 + m_d);
        IN_VALID   = k_iv;
        IN_OP      = k_op;
        IN_A       = k_a;
        IN_B       = k_b;
        OUT_READY  = k_ordy;
        CLR_STICKY = k_clr;
        DP_DONE    = done_now || (k_sp && !m_in_exec());
        DP_RESULT  = done_now ? m_dpres : 8'($urandom);
    endtask

    task automatic model_edge();
        logic [2:0] set;
        if (RST_N !== 1'b1) return;
        set = (m_busy && m_cyc + 1 == m_lat) ? m_set : 3'b000;
        m_sticky = (CLR_STICKY ? 3'b000 : m_sticky) | set;
        if (m_busy) begin
            if (m_cyc >= m_lat && OUT_READY) m_busy = 1'b0;
            else m_cyc++;
        end else if (IN_VALID) begin
            m_op = IN_OP; m_a = IN_A; m_b = IN_B;
            m_d = k_d; m_dpres = k_dpres;
            m_code = chk_fn(m_op, m_a, m_b);
            m_busy = 1'b1; m_cyc = 1; m_to = 1'b0; m_set = 3'b000;
            if (m_code != `_NO_EXCE) begin
                m_exc = 1'b1;
                m_lat = 2;
                m_res = (m_code == `_ZERO_DIV_EXCE) ? {m_a[7] ^ m_b[7], 7'h78} : 8'hFF;
                m_set[1] = (m_code == `_ZERO_DIV_EXCE);
                m_set[0] = (m_code == `_qNAN_EXCE) || (m_code == `_sNAN_EXCE) || (m_code == `_INF_EXCE);
            end else begin
                m_exc = 1'b0;
                if (m_d <= TO) begin
                    m_lat = 2 + m_d;
                    m_res = m_dpres;
                end else begin
                    m_lat = 2 + TO;
                    m_res = 8'hFF;
                    m_to  = 1'b1;
                    m_set = 3'b100;
                end
            end
        end
    endtask

    task automatic compare();
        bit ev;
        ev = m_busy && m_cyc >= m_lat;
        check("in_ready", IN_READY, m_busy ? 1'b0 : 1'b1);
        check("dp_start", DP_START, (m_busy && !m_exc && m_cyc == 1) ? 1'b1 : 1'b0);
        check("out_valid", OUT_VALID, ev);
        check("exc_op", EXC_OP, m_op);
        check("exc_a", EXC_A, m_a);
        check("exc_b", EXC_B, m_b);
        check("sticky", STICKY, m_sticky);
        if (ev) begin
            check("out_result", OUT_RESULT, m_res);
            check("out_exce", OUT_EXCE, m_code);
            check("out_timeout", OUT_TIMEOUT, m_to);
        end else begin
            check("out_timeout_idle", OUT_TIMEOUT, 1'b0);
        end
        if (DP_START === 1'b1) dp_starts++;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle();
        apply_inputs();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        compare();
    endtask

    task automatic pulse_reset(input int hold);
        RST_N = 1'b0;
        #1;
        check("rst_out_valid", OUT_VALID, 1'b0);
        check("rst_dp_start", DP_START, 1'b0);
        check("rst_out_result", OUT_RESULT, 8'h00);
        check("rst_out_exce", OUT_EXCE, `_NO_EXCE);
        check("rst_out_timeout", OUT_TIMEOUT, 1'b0);
        check("rst_sticky", STICKY, 3'b000);
        check("rst_exc_abop", {EXC_OP, EXC_A, EXC_B}, 18'd0);
        m_busy = 1'b0; m_cyc = 0; m_lat = 0; m_exc = 1'b0;
        m_op = 2'd0; m_a = 8'd0; m_b = 8'd0; m_sticky = 3'b000;
        repeat (hold) cycle();
        RST_N = 1'b1;
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int d, input logic [7:0] dpres, output int lat);
        k_iv = 1'b1; k_op = op; k_a = a; k_b = b; k_d = d; k_dpres = dpres;
        k_ordy = 1'b0; k_clr = 1'b0; k_sp = 1'b0;
        dp_starts = 0;
        cycle();
        k_iv = 1'b0;
        for (int i = 0; i < 40 && !(m_busy && m_cyc >= m_lat); i++) cycle();
        lat = m_cyc;
    endtask

    task automatic handshake(input bit clr);
        k_ordy = 1'b1; k_iv = 1'b0; k_clr = clr;
        cycle();
        k_ordy = 1'b0; k_clr = 1'b0;
    endtask

    function automatic logic [7:0] pick();
        if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 7))
                0: return 8'h00;
                1: return 8'h80;
                2: return 8'h78;
                3: return 8'hF8;
                4: return 8'h79;
                5: return 8'h7C;
                6: return 8'hFF;
                default: return 8'hB8;
            endcase
        end
        return 8'($urandom);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r;
        k_iv = 0; k_ordy = 0; k_clr = 0; k_sp = 0;
        k_op = 2'd0; k_a = 8'd0; k_b = 8'd0; k_d = 1; k_dpres = 8'd0;
        m_busy = 0; m_cyc = 0; m_lat = 0; m_d = 0; m_exc = 0; m_to = 0;
        m_op = 2'd0; m_a = 8'd0; m_b = 8'd0; m_res = 8'd0; m_dpres = 8'd0;
        m_code = `_NO_EXCE; m_set = 3'b000; m_sticky = 3'b000;

        @(negedge CLK);
        pulse_reset(2);

        // Datapath add, done three cycles after the start pulse.
        run_txn(`_ADDITION, 8'h38, 8'h38, 3, 8'h40, lat);
        check("t1_latency", lat, 5);
        check("t1_result", OUT_RESULT, 8'h40);
        check("t1_exce", OUT_EXCE, `_NO_EXCE);
        check("t1_sticky", STICKY, 3'b000);
        check("t1_starts", dp_starts, 1);
        handshake(1'b0);

        // Divide by zero: signed infinity, no start pulse.
        run_txn(`_DIVISION, 8'hB8, 8'h00, 3, 8'h00, lat);
        check("t2_latency", lat, 2);
        check("t2_result", OUT_RESULT, 8'hF8);
        check("t2_exce", OUT_EXCE, `_ZERO_DIV_EXCE);
        check("t2_sticky", STICKY, 3'b010);
        check("t2_starts", dp_starts, 0);
        handshake(1'b1);
        check("t2_sticky_clr", STICKY, 3'b000);

        // Signalling NaN operand.
        run_txn(`_SUBTRACTION, 8'h79, 8'h38, 3, 8'h00, lat);
        check("t3_result", OUT_RESULT, 8'hFF);
        check("t3_exce", OUT_EXCE, `_sNAN_EXCE);
        check("t3_sticky", STICKY, 3'b001);
        handshake(1'b0);
        k_clr = 1'b1;
        cycle();
        k_clr = 1'b0;
        check("t3_sticky_clr", STICKY, 3'b000);

        // Timeout, then completion on the last EXEC cycle.
        run_txn(`_MULTIPLICATION, 8'h38, 8'h38, 40, 8'h00, lat);
        check("t4_latency", lat, 18);
        check("t4_result", OUT_RESULT, 8'hFF);
        check("t4_timeout", OUT_TIMEOUT, 1'b1);
        check("t4_sticky", STICKY, 3'b100);
        handshake(1'b0);
        check("t4_timeout_clr", OUT_TIMEOUT, 1'b0);
        run_txn(`_MULTIPLICATION, 8'h38, 8'h38, 16, 8'h5A, lat);
        check("t4b_latency", lat, 18);
        check("t4b_result", OUT_RESULT, 8'h5A);
        check("t4b_timeout", OUT_TIMEOUT, 1'b0);
        handshake(1'b1);

        // Back-pressure with a second request waiting.
        run_txn(`_ADDITION, 8'h38, 8'h38, 1, 8'h11, lat);
        check("t5_latency", lat, 3);
        k_iv = 1'b1; k_op = `_ADDITION; k_a = 8'h55; k_b = 8'h38; k_d = 2; k_dpres = 8'h22;
        repeat (10) cycle();
        check("t5_hold_a", EXC_A, 8'h38);
        check("t5_hold_res", OUT_RESULT, 8'h11);
        check("t5_hold_ready", IN_READY, 1'b0);
        k_ordy = 1'b1;
        cycle();
        k_ordy = 1'b0;
        check("t5_ready_after", IN_READY, 1'b1);
        cycle();
        k_iv = 1'b0;
        check("t5_new_a", EXC_A, 8'h55);
        for (int i = 0; i < 40 && !(m_busy && m_cyc >= m_lat); i++) cycle();
        check("t5_new_res", OUT_RESULT, 8'h22);
        handshake(1'b0);

        // Reset in the middle of EXEC, then a stray completion pulse.
        k_iv = 1'b1; k_op = `_MULTIPLICATION; k_a = 8'h38; k_b = 8'h38; k_d = 10; k_dpres = 8'h33;
        cycle();
        k_iv = 1'b0;
        repeat (4) cycle();
        pulse_reset(2);
        k_sp = 1'b1;
        cycle();
        k_sp = 1'b0;
        check("t6_no_valid", OUT_VALID, 1'b0);
        check("t6_ready", IN_READY, 1'b1);
        run_txn(`_ADDITION, 8'h44, 8'h38, 2, 8'h66, lat);
        check("t6_latency", lat, 4);
        check("t6_new_a", EXC_A, 8'h44);
        check("t6_result", OUT_RESULT, 8'h66);
        handshake(1'b0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            k_iv    = ($urandom_range(0, 1) == 1);
            k_op    = 2'($urandom);
            k_a     = pick();
            k_b     = pick();
            r       = $urandom_range(0, 9);
            k_d     = (r < 6) ? $urandom_range(1, 8) : (r < 8) ? $urandom_range(15, 17) : $urandom_range(18, 20);
            k_dpres = 8'($urandom);
            k_ordy  = ($urandom_range(0, 3) != 0);
            k_clr   = ($urandom_range(0, 7) == 0);
            k_sp    = ($urandom_range(0, 3) == 0);
            if (n == 700) pulse_reset(1);
            cycle();
        end
        k_iv = 1'b0; k_ordy = 1'b1; k_clr = 1'b0; k_sp = 1'b0;
        repeat (25) cycle();
        check("drain_idle", IN_READY, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
